// File: rtl/prog_loader.sv
// Program loader: receives a length byte, N five-byte instruction words and an
// XOR checksum over a byte stream, and writes each word into program memory.
module prog_loader #(
    parameter int AW = 8,
    parameter int WW = 35
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [AW-1:0] pm_addr,
    output logic [WW-1:0] pm_data,
    output logic          pm_we,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_BYTE,
        S_WRITE,
        S_CSUM,
        S_FIN
    } state_t;

    localparam logic [AW:0] ONE = 1;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_len;
    logic [7:0]      r_csum;
    logic [2:0]      r_byteIdx;
    logic [WW-9:0]   r_word;
    logic [AW-1:0]   r_pmAddr;
    logic [WW-1:0]   r_pmData;
    logic            r_done;
    logic            r_err;
    logic [AW:0]     r_wordCount;
    logic            w_accept;
    logic            w_lastByte;
    logic            w_badByte0;
    logic            w_lastWord;
    logic            w_pmWe;

    assign rx_ready   = (r_state == S_LEN) || (r_state == S_BYTE) || (r_state == S_CSUM);
    assign busy       = (r_state != S_IDLE);
    assign w_accept   = rx_valid && rx_ready;
    assign w_lastByte = (r_byteIdx == 3'd4);
    assign w_badByte0 = (r_byteIdx == 3'd0) && (rx_data[7:3] != 5'd0);
    assign w_lastWord = ((r_wordCount + ONE) == {{(AW-7){1'b0}}, r_len});

    assign pm_we      = w_pmWe;
    assign pm_addr    = r_pmAddr;
    assign pm_data    = r_pmData;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_wordCount;

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and write strobe; abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        w_pmWe = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_accept) w_next = (rx_data == 8'd0) ? S_CSUM : S_BYTE;
            end
            S_BYTE: begin
                if (w_accept) begin
                    if (w_badByte0)      w_next = S_FIN;
                    else if (w_lastByte) w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_pmWe = 1'b1;
                w_next = w_lastWord ? S_CSUM : S_BYTE;
            end
            S_CSUM: begin
                if (w_accept) w_next = S_FIN;
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next = S_IDLE;
            w_pmWe = 1'b0;
        end
    end

    // Datapath: word assembly, checksum, write address/data and status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_len       <= '0;
            r_csum      <= '0;
            r_byteIdx   <= '0;
            r_word      <= '0;
            r_pmAddr    <= '0;
            r_pmData    <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_wordCount <= '0;
        end else if (abort) begin
            r_done <= 1'b0;
            r_err  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_wordCount <= '0;
                        r_byteIdx   <= '0;
                        r_csum      <= '0;
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        r_len  <= rx_data;
                        r_csum <= rx_data;
                    end
                end
                S_BYTE: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ rx_data;
                        if (w_badByte0) begin
                            r_err <= 1'b1;
                        end else if (w_lastByte) begin
                            r_byteIdx <= '0;
                            r_pmAddr  <= r_wordCount[AW-1:0];
                            r_pmData  <= {r_word, rx_data};
                        end else begin
                            r_byteIdx <= r_byteIdx + 3'd1;
                            if (r_byteIdx == 3'd0)
                                r_word <= {{(WW-11){1'b0}}, rx_data[2:0]};
                            else
                                r_word <= {r_word[WW-17:0], rx_data};
                        end
                    end
                end
                S_WRITE: begin
                    r_wordCount <= r_wordCount + ONE;
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (rx_data == r_csum) r_done <= 1'b1;
                        else                   r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: directed and randomized loads checked against a
// byte-stream reference model that computes the expected memory writes.
module tb_prog_loader;

    localparam int AW = 8;
    localparam int WW = 35;

    logic          clock;
    logic          reset;
    logic          start;
    logic          abort;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] pm_addr;
    logic [WW-1:0] pm_data;
    logic          pm_we;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]    stream[$];
    logic [AW-1:0] capAddr[$];
    logic [WW-1:0] capData[$];
    logic [AW-1:0] expAddr[$];
    logic [WW-1:0] expData[$];
    logic          expDone;
    logic          expErr;
    int            expCount;
    int            expBytes;

    prog_loader #(.AW(AW), .WW(WW)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .pm_addr(pm_addr), .pm_data(pm_data), .pm_we(pm_we),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every memory write seen mid-cycle.
    always @(negedge clock) begin
        if (pm_we === 1'b1) begin
            capAddr.push_back(pm_addr);
            capData.push_back(pm_data);
        end
    end

    // Reference model: walk the byte stream and derive writes and final status.
    task automatic modelLoad();
        int n;
        int used;
        logic [7:0] acc;
        logic [7:0] b0;
        longint word;
        expAddr.delete();
        expData.delete();
        expDone = 1'b0;
        expErr  = 1'b0;
        n    = int'(stream[0]);
        acc  = stream[0];
        used = 1;
        for (int w = 0; w < n; w++) begin
            b0 = stream[used];
            used++;
            acc ^= b0;
            if (b0 > 8'd7) begin
                expErr   = 1'b1;
                expBytes = used;
                expCount = w;
                return;
            end
            word = longint'(b0);
            for (int k = 0; k < 4; k++) begin
                word = word * 256 + longint'(stream[used]);
                acc ^= stream[used];
                used++;
            end
            expAddr.push_back(w[AW-1:0]);
            expData.push_back(word[WW-1:0]);
        end
        if (stream[used] == acc) expDone = 1'b1;
        else                     expErr  = 1'b1;
        used++;
        expBytes = used;
        expCount = n;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            rx_valid = 1'b0;
            @(negedge clock);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL sendByte timeout: rx_ready=%b required 1", rx_ready);
        end
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    // Drive the whole stream, then compare captured writes and status to the model.
    task automatic runLoad(input bit gaps, input bit midStart, input string name);
        capAddr.delete();
        capData.delete();
        modelLoad();
        pulseStart();
        for (int i = 0; i < expBytes; i++) begin
            sendByte(stream[i], gaps);
            if (midStart && i == 3) pulseStart();
        end
        repeat (3) @(negedge clock);
        checks++;
        if ({done, err} !== {expDone, expErr}) begin
            errors++;
            $display("[TB] FAIL %s status: done/err=%b%b required %b%b", name, done, err, expDone, expErr);
        end
        checks++;
        if (word_count !== expCount[AW:0] || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s count: word_count=%0d busy=%b required %0d 0", name, word_count, busy, expCount);
        end
        checks++;
        if (capAddr.size() != expAddr.size()) begin
            errors++;
            $display("[TB] FAIL %s writes: got %0d required %0d", name, capAddr.size(), expAddr.size());
        end else begin
            for (int i = 0; i < expAddr.size(); i++) begin
                checks++;
                if (capAddr[i] !== expAddr[i] || capData[i] !== expData[i]) begin
                    errors++;
                    $display("[TB] FAIL %s write%0d: %h@%h required %h@%h", name, i, capData[i], capAddr[i], expData[i], expAddr[i]);
                end
            end
        end
    endtask

    task automatic setTwoWordStream(input logic [7:0] csum);
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                   8'h07, 8'hFF, 8'hFF, 8'hFF, 8'hFF, csum};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if ({rx_ready, pm_we, pm_addr, pm_data, busy, done, err, word_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset values: %b required all zero",
                     {rx_ready, pm_we, pm_addr, pm_data, busy, done, err, word_count});
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Two-word load with explicit checks of the write-strobe latency.
    task automatic test_two_words();
        capAddr.delete();
        capData.delete();
        setTwoWordStream(8'h04);
        pulseStart();
        for (int i = 0; i < 6; i++) sendByte(stream[i], 1'b0);
        checks++;
        if (pm_we !== 1'b1 || pm_addr !== 8'd0 || pm_data !== 35'h1) begin
            errors++;
            $display("[TB] FAIL write0 latency: we=%b addr=%h data=%h required 1 00 1", pm_we, pm_addr, pm_data);
        end
        for (int i = 6; i < 11; i++) sendByte(stream[i], 1'b0);
        checks++;
        if (pm_we !== 1'b1 || pm_addr !== 8'd1 || pm_data !== 35'h7FFFFFFFF) begin
            errors++;
            $display("[TB] FAIL write1 latency: we=%b addr=%h data=%h required 1 01 7ffffffff", pm_we, pm_addr, pm_data);
        end
        sendByte(stream[11], 1'b0);
        repeat (2) @(negedge clock);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || word_count !== 9'd2 || pm_we !== 1'b0 || pm_addr !== 8'd1) begin
            errors++;
            $display("[TB] FAIL two-word final: done=%b err=%b cnt=%0d we=%b addr=%h required 1 0 2 0 01",
                     done, err, word_count, pm_we, pm_addr);
        end
        checks++;
        if (capAddr.size() != 2) begin
            errors++;
            $display("[TB] FAIL two-word writes: got %0d required 2", capAddr.size());
        end
    endtask

    task automatic test_bad_csum();
        setTwoWordStream(8'h05);
        runLoad(1'b0, 1'b0, "bad_csum");
    endtask

    task automatic test_zero_len();
        stream = '{8'h00, 8'h00};
        runLoad(1'b0, 1'b0, "zero_len");
    endtask

    task automatic test_bad_byte0();
        capAddr.delete();
        capData.delete();
        pulseStart();
        sendByte(8'h01, 1'b0);
        sendByte(8'h08, 1'b0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_byte0 fin: err=%b busy=%b done=%b required 1 1 0", err, busy, done);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || capAddr.size() != 0) begin
            errors++;
            $display("[TB] FAIL bad_byte0 idle: busy=%b err=%b writes=%0d required 0 1 0", busy, err, capAddr.size());
        end
    endtask

    task automatic test_back_to_back();
        setTwoWordStream(8'h04);
        runLoad(1'b1, 1'b1, "backpressure");
    endtask

    task automatic test_abort();
        pulseStart();
        sendByte(8'h03, 1'b0);
        sendByte(8'h01, 1'b0);
        sendByte(8'h22, 1'b0);
        abort    = 1'b1;
        start    = 1'b1;
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        @(negedge clock);
        abort    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort: busy=%b err=%b done=%b ready=%b required 0 1 0 0", busy, err, done, rx_ready);
        end
    endtask

    task automatic test_reset_mid();
        capAddr.delete();
        capData.delete();
        setTwoWordStream(8'h04);
        pulseStart();
        for (int i = 0; i < 8; i++) sendByte(stream[i], 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if ({rx_ready, pm_we, pm_addr, pm_data, busy, done, err, word_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid values: %b required all zero",
                     {rx_ready, pm_we, pm_addr, pm_data, busy, done, err, word_count});
        end
        for (int i = 8; i < 12; i++) begin
            rx_data  = stream[i];
            rx_valid = 1'b1;
            @(negedge clock);
        end
        rx_valid = 1'b0;
        reset = 1'b1;
        repeat (8) @(negedge clock);
        checks++;
        if (capAddr.size() != 1 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid after: writes=%0d done=%b err=%b busy=%b required 1 0 0 0",
                     capAddr.size(), done, err, busy);
        end
    endtask

    // Random lengths, payloads, occasional bad byte0 and corrupted checksum.
    task automatic test_random();
        int n;
        logic [7:0] acc;
        logic [7:0] b;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 5);
            stream.delete();
            stream.push_back(n[7:0]);
            acc = n[7:0];
            for (int w = 0; w < n; w++) begin
                if ($urandom_range(0, 11) == 0) b = 8'h08 | 8'($urandom_range(0, 255));
                else                            b = 8'($urandom_range(0, 7));
                stream.push_back(b);
                acc ^= b;
                for (int k = 0; k < 4; k++) begin
                    b = 8'($urandom_range(0, 255));
                    stream.push_back(b);
                    acc ^= b;
                end
            end
            if ($urandom_range(0, 3) == 0) acc ^= 8'(1 << $urandom_range(0, 7));
            stream.push_back(acc);
            runLoad(bit'($urandom_range(0, 1)), 1'b0, "random");
        end
    endtask

    initial begin
        start    = 1'b0;
        abort    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        test_reset();
        test_two_words();
        test_bad_csum();
        test_zero_len();
        test_bad_byte0();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
